renode_axi_burst_normalizer: RTL and testbench

Synthesizable AXI4 stage placed directly upstream of the Renode AXI subordinate, between the DUT manager and the co-simulation port. It turns every upstream burst (FIXED, INCR or WRAP, any length) into a sequence of single-beat INCR transactions (len=0) on the downstream bus. This lets the subordinate serve FIXED and WRAP traffic it otherwise rejects. Read and write paths are independent, each handles one burst at a time, and downstream responses are merged back into a single upstream burst response.

---
 rtl/renode_axi_burst_normalizer_if.sv | 72 +++++++
 rtl/renode_axi_burst_normalizer.sv | 329 ++++++++++++++++++++++++++++++++
 tb/tb_renode_axi_burst_normalizer.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/renode_axi_burst_normalizer_if.sv
// -----------------------------------------------------------------------------
// renode_axi_if
// AXI4 bundle shared by the DUT manager, the burst normalizer and the Renode
// co-simulation subordinate.
//   aclk, areset_n : carried for the endpoints that need them.
//   aw*/w*/b*      : write address, write data and write response channels.
//   ar*/r*         : read address and read data channels.
// Modports: manager drives requests and write data; subordinate drives readies,
// responses and read data.
// -----------------------------------------------------------------------------
interface renode_axi_if #(
  parameter int AddressWidth       = 32,
  parameter int DataWidth          = 32,
  parameter int TransactionIdWidth = 8
) (
  input logic aclk,
  input logic areset_n
);
  localparam int StrobeWidth = DataWidth / 8;

  logic [TransactionIdWidth-1:0] awid;
  logic [AddressWidth-1:0]       awaddr;
  logic [7:0]                    awlen;
  logic [2:0]                    awsize;
  logic [1:0]                    awburst;
  logic                          awvalid;
  logic                          awready;

  logic [DataWidth-1:0]          wdata;
  logic [StrobeWidth-1:0]        wstrb;
  logic                          wlast;
  logic                          wvalid;
  logic                          wready;

  logic [TransactionIdWidth-1:0] bid;
  logic [1:0]                    bresp;
  logic                          bvalid;
  logic                          bready;

  logic [TransactionIdWidth-1:0] arid;
  logic [AddressWidth-1:0]       araddr;
  logic [7:0]                    arlen;
  logic [2:0]                    arsize;
  logic [1:0]                    arburst;
  logic                          arvalid;
  logic                          arready;

  logic [TransactionIdWidth-1:0] rid;
  logic [DataWidth-1:0]          rdata;
  logic [1:0]                    rresp;
  logic                          rlast;
  logic                          rvalid;
  logic                          rready;

  modport manager (
    input  aclk, areset_n,
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready
  );

  modport subordinate (
    input  aclk, areset_n,
    input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/renode_axi_burst_normalizer.sv
// -----------------------------------------------------------------------------
// renode_axi_burst_normalizer
// Splits every upstream AXI4 burst (FIXED, INCR, WRAP, any length) into a
// series of single-beat INCR transactions downstream and merges the downstream
// responses back into one upstream burst response. Read and write paths are
// independent FSMs, each owning one burst at a time.
//   aclk     : clock, rising edge
//   areset_n : asynchronous active-low reset
//   s_bus    : upstream port (faces the DUT manager)
//   m_bus    : downstream port (faces the Renode AXI subordinate)
// Illegal bursts (reserved type, malformed WRAP) never reach m_bus: reads are
// answered locally with SLVERR beats, writes are drained and answered SLVERR.
// -----------------------------------------------------------------------------
module renode_axi_burst_normalizer #(
  parameter int AddressWidth       = 32,
  parameter int DataWidth          = 32,
  parameter int TransactionIdWidth = 8
) (
  input logic                  aclk,
  input logic                  areset_n,
  renode_axi_if.subordinate    s_bus,
  renode_axi_if.manager        m_bus
);
  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;
  localparam logic [1:0] BURST_RSVD  = 2'd3;
  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;

  typedef enum logic [1:0] {RD_IDLE, RD_AR, RD_R, RD_ERR} rd_state_e;
  typedef enum logic [2:0] {WR_IDLE, WR_AW, WR_W, WR_B, WR_RESP, WR_DRAIN} wr_state_e;

  function automatic logic burst_invalid(input logic [1:0] burst, input logic [7:0] len,
                                         input logic [AddressWidth-1:0] addr,
                                         input logic [2:0] size);
    logic [AddressWidth-1:0] mask;
    mask = (AddressWidth'(1) << size) - AddressWidth'(1);
    if (burst == BURST_RSVD) return 1'b1;
    if (burst == BURST_WRAP) begin
      if (!(len inside {8'd1, 8'd3, 8'd7, 8'd15})) return 1'b1;
      if ((addr & mask) != '0) return 1'b1;
    end
    return 1'b0;
  endfunction

  // WRAP windows are always a power of two (len+1 in {2,4,8,16}), so the
  // modulo reduces to a mask.
  function automatic logic [AddressWidth-1:0] next_addr(input logic [1:0] burst,
                                                        input logic [7:0] len,
                                                        input logic [2:0] size,
                                                        input logic [AddressWidth-1:0] start,
                                                        input logic [AddressWidth-1:0] cur);
    logic [AddressWidth-1:0] bytes;
    logic [AddressWidth-1:0] window;
    logic [AddressWidth-1:0] base;
    logic [AddressWidth-1:0] nxt;
    bytes  = AddressWidth'(1) << size;
    window = bytes * (AddressWidth'(len) + AddressWidth'(1));
    base   = start & ~(window - AddressWidth'(1));
    case (burst)
      BURST_INCR: nxt = (cur & ~(bytes - AddressWidth'(1))) + bytes;
      BURST_WRAP: nxt = base + ((cur + bytes - base) & (window - AddressWidth'(1)));
      default:    nxt = cur;
    endcase
    return nxt;
  endfunction

  // Response codes are numerically ordered OKAY<EXOKAY<SLVERR<DECERR.
  function automatic logic [1:0] resp_merge(input logic [1:0] a, input logic [1:0] b);
    return (b > a) ? b : a;
  endfunction

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  rd_state_e                     rd_state_q, rd_state_d;
  logic [TransactionIdWidth-1:0] rd_id_q, rd_id_d;
  logic [AddressWidth-1:0]       rd_start_q, rd_start_d;
  logic [AddressWidth-1:0]       rd_addr_q, rd_addr_d;
  logic [2:0]                    rd_size_q, rd_size_d;
  logic [7:0]                    rd_len_q, rd_len_d;
  logic [1:0]                    rd_burst_q, rd_burst_d;
  logic [7:0]                    rd_beat_q, rd_beat_d;
  logic                          rd_last;

  assign rd_last = (rd_beat_q == rd_len_q);

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      rd_state_q <= RD_IDLE;
      rd_id_q    <= '0;
      rd_start_q <= '0;
      rd_addr_q  <= '0;
      rd_size_q  <= '0;
      rd_len_q   <= '0;
      rd_burst_q <= '0;
      rd_beat_q  <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_id_q    <= rd_id_d;
      rd_start_q <= rd_start_d;
      rd_addr_q  <= rd_addr_d;
      rd_size_q  <= rd_size_d;
      rd_len_q   <= rd_len_d;
      rd_burst_q <= rd_burst_d;
      rd_beat_q  <= rd_beat_d;
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_id_d    = rd_id_q;
    rd_start_d = rd_start_q;
    rd_addr_d  = rd_addr_q;
    rd_size_d  = rd_size_q;
    rd_len_d   = rd_len_q;
    rd_burst_d = rd_burst_q;
    rd_beat_d  = rd_beat_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (s_bus.arvalid) begin
          rd_id_d    = s_bus.arid;
          rd_start_d = s_bus.araddr;
          rd_addr_d  = s_bus.araddr;
          rd_size_d  = s_bus.arsize;
          rd_len_d   = s_bus.arlen;
          rd_burst_d = s_bus.arburst;
          rd_beat_d  = '0;
          rd_state_d = burst_invalid(s_bus.arburst, s_bus.arlen, s_bus.araddr, s_bus.arsize)
                       ? RD_ERR : RD_AR;
        end
      end
      RD_AR: begin
        if (m_bus.arready) rd_state_d = RD_R;
      end
      RD_R: begin
        if (m_bus.rvalid && s_bus.rready) begin
          if (rd_last) begin
            rd_state_d = RD_IDLE;
          end else begin
            rd_beat_d  = rd_beat_q + 8'd1;
            rd_addr_d  = next_addr(rd_burst_q, rd_len_q, rd_size_q, rd_start_q, rd_addr_q);
            rd_state_d = RD_AR;
          end
        end
      end
      RD_ERR: begin
        if (s_bus.rready) begin
          if (rd_last) rd_state_d = RD_IDLE;
          else         rd_beat_d  = rd_beat_q + 8'd1;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_comb begin
    s_bus.arready = (rd_state_q == RD_IDLE);
    m_bus.arvalid = (rd_state_q == RD_AR);
    m_bus.araddr  = rd_addr_q;
    m_bus.arid    = rd_id_q;
    m_bus.arlen   = 8'd0;
    m_bus.arsize  = rd_size_q;
    m_bus.arburst = BURST_INCR;
    s_bus.rid     = rd_id_q;
    s_bus.rvalid  = 1'b0;
    s_bus.rdata   = '0;
    s_bus.rresp   = RESP_OKAY;
    s_bus.rlast   = 1'b0;
    m_bus.rready  = 1'b0;
    case (rd_state_q)
      RD_R: begin
        s_bus.rvalid = m_bus.rvalid;
        s_bus.rdata  = m_bus.rdata;
        s_bus.rresp  = m_bus.rresp;
        s_bus.rlast  = rd_last;
        m_bus.rready = s_bus.rready;
      end
      RD_ERR: begin
        s_bus.rvalid = 1'b1;
        s_bus.rresp  = RESP_SLVERR;
        s_bus.rlast  = rd_last;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------
  wr_state_e                     wr_state_q, wr_state_d;
  logic [TransactionIdWidth-1:0] wr_id_q, wr_id_d;
  logic [AddressWidth-1:0]       wr_start_q, wr_start_d;
  logic [AddressWidth-1:0]       wr_addr_q, wr_addr_d;
  logic [2:0]                    wr_size_q, wr_size_d;
  logic [7:0]                    wr_len_q, wr_len_d;
  logic [1:0]                    wr_burst_q, wr_burst_d;
  logic [7:0]                    wr_beat_q, wr_beat_d;
  logic [1:0]                    wr_resp_q, wr_resp_d;
  logic                          wr_last;

  assign wr_last = (wr_beat_q == wr_len_q);

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      wr_state_q <= WR_IDLE;
      wr_id_q    <= '0;
      wr_start_q <= '0;
      wr_addr_q  <= '0;
      wr_size_q  <= '0;
      wr_len_q   <= '0;
      wr_burst_q <= '0;
      wr_beat_q  <= '0;
      wr_resp_q  <= RESP_OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      wr_id_q    <= wr_id_d;
      wr_start_q <= wr_start_d;
      wr_addr_q  <= wr_addr_d;
      wr_size_q  <= wr_size_d;
      wr_len_q   <= wr_len_d;
      wr_burst_q <= wr_burst_d;
      wr_beat_q  <= wr_beat_d;
      wr_resp_q  <= wr_resp_d;
    end
  end

  always_comb begin
    wr_state_d = wr_state_q;
    wr_id_d    = wr_id_q;
    wr_start_d = wr_start_q;
    wr_addr_d  = wr_addr_q;
    wr_size_d  = wr_size_q;
    wr_len_d   = wr_len_q;
    wr_burst_d = wr_burst_q;
    wr_beat_d  = wr_beat_q;
    wr_resp_d  = wr_resp_q;
    case (wr_state_q)
      WR_IDLE: begin
        if (s_bus.awvalid) begin
          wr_id_d    = s_bus.awid;
          wr_start_d = s_bus.awaddr;
          wr_addr_d  = s_bus.awaddr;
          wr_size_d  = s_bus.awsize;
          wr_len_d   = s_bus.awlen;
          wr_burst_d = s_bus.awburst;
          wr_beat_d  = '0;
          wr_resp_d  = RESP_OKAY;
          wr_state_d = burst_invalid(s_bus.awburst, s_bus.awlen, s_bus.awaddr, s_bus.awsize)
                       ? WR_DRAIN : WR_AW;
        end
      end
      WR_AW: begin
        if (m_bus.awready) wr_state_d = WR_W;
      end
      WR_W: begin
        if (s_bus.wvalid && m_bus.wready) begin
          // A misplaced wlast is a protocol error by the manager; keep any
          // worse response already collected.
          if (s_bus.wlast != wr_last) wr_resp_d = resp_merge(wr_resp_q, RESP_SLVERR);
          wr_state_d = WR_B;
        end
      end
      WR_B: begin
        if (m_bus.bvalid) begin
          wr_resp_d = resp_merge(wr_resp_q, m_bus.bresp);
          if (wr_last) begin
            wr_state_d = WR_RESP;
          end else begin
            wr_beat_d  = wr_beat_q + 8'd1;
            wr_addr_d  = next_addr(wr_burst_q, wr_len_q, wr_size_q, wr_start_q, wr_addr_q);
            wr_state_d = WR_AW;
          end
        end
      end
      WR_RESP: begin
        if (s_bus.bready) wr_state_d = WR_IDLE;
      end
      WR_DRAIN: begin
        if (s_bus.wvalid) begin
          if (wr_last) begin
            wr_resp_d  = RESP_SLVERR;
            wr_state_d = WR_RESP;
          end else begin
            wr_beat_d  = wr_beat_q + 8'd1;
          end
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  always_comb begin
    s_bus.awready = (wr_state_q == WR_IDLE);
    m_bus.awvalid = (wr_state_q == WR_AW);
    m_bus.awaddr  = wr_addr_q;
    m_bus.awid    = wr_id_q;
    m_bus.awlen   = 8'd0;
    m_bus.awsize  = wr_size_q;
    m_bus.awburst = BURST_INCR;
    s_bus.wready  = 1'b0;
    m_bus.wvalid  = 1'b0;
    m_bus.wdata   = '0;
    m_bus.wstrb   = '0;
    m_bus.wlast   = 1'b0;
    m_bus.bready  = (wr_state_q == WR_B);
    s_bus.bvalid  = (wr_state_q == WR_RESP);
    s_bus.bid     = wr_id_q;
    s_bus.bresp   = (wr_state_q == WR_RESP) ? wr_resp_q : RESP_OKAY;
    case (wr_state_q)
      WR_W: begin
        s_bus.wready = m_bus.wready;
        m_bus.wvalid = s_bus.wvalid;
        m_bus.wdata  = s_bus.wdata;
        m_bus.wstrb  = s_bus.wstrb;
        m_bus.wlast  = 1'b1;
      end
      WR_DRAIN: s_bus.wready = 1'b1;
      default: ;
    endcase
  end

  // Downstream IDs and rlast carry nothing the normalizer needs: IDs are
  // regenerated from the latched upstream ID and every downstream read is
  // a single beat.
  logic unused_inputs;
  assign unused_inputs = ^{m_bus.bid, m_bus.rid, m_bus.rlast, BURST_FIXED};
endmodule

// File: tb/tb_renode_axi_burst_normalizer.sv
module tb_renode_axi_burst_normalizer;
  localparam logic [1:0] FIXED = 2'd0;
  localparam logic [1:0] INCR  = 2'd1;
  localparam logic [1:0] WRAP  = 2'd2;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  renode_axi_if #(.AddressWidth(32), .DataWidth(32), .TransactionIdWidth(8))
    s_bus (.aclk(clk), .areset_n(rst_n));
  renode_axi_if #(.AddressWidth(32), .DataWidth(32), .TransactionIdWidth(8))
    m_bus (.aclk(clk), .areset_n(rst_n));

  renode_axi_burst_normalizer #(.AddressWidth(32), .DataWidth(32), .TransactionIdWidth(8))
    dut (.aclk(clk), .areset_n(rst_n), .s_bus(s_bus), .m_bus(m_bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream observation and response tables.
  logic [31:0] ar_addr_q[$], ar_len_q[$], ar_burst_q[$], ar_id_q[$];
  logic [31:0] aw_addr_q[$], aw_len_q[$], aw_burst_q[$], aw_id_q[$];
  logic [31:0] w_data_q[$], w_last_q[$];
  logic [31:0] r_data_q[$], r_resp_q[$], r_last_q[$], r_id_q[$];
  logic [1:0]  rresp_tbl[16];
  logic [1:0]  bresp_tbl[16];
  int          rresp_idx;
  int          bresp_idx;
  logic [31:0] w_src[16];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hBAD0_BAD0;
  endfunction

  // Downstream read subordinate: always ready for AR, answers one beat later.
  initial begin : rd_model
    logic ar_pend;
    logic r_pend;
    logic [31:0] last_addr;
    ar_pend = 1'b0; r_pend = 1'b0; last_addr = '0;
    m_bus.arready = 1'b1; m_bus.rvalid = 1'b0; m_bus.rdata = '0;
    m_bus.rresp = 2'd0; m_bus.rid = '0; m_bus.rlast = 1'b0;
    forever begin
      @(negedge clk);
      if (r_pend) begin m_bus.rvalid = 1'b0; m_bus.rlast = 1'b0; end
      if (ar_pend) begin
        m_bus.rvalid = 1'b1;
        m_bus.rlast  = 1'b1;
        m_bus.rdata  = 32'hD000_0000 ^ last_addr;
        m_bus.rresp  = rresp_tbl[rresp_idx[3:0]];
        rresp_idx++;
      end
      #1;
      if (!rst_n) begin
        m_bus.rvalid = 1'b0; ar_pend = 1'b0; r_pend = 1'b0;
      end else begin
        ar_pend = m_bus.arvalid && m_bus.arready;
        if (ar_pend) begin
          last_addr = m_bus.araddr;
          m_bus.rid = m_bus.arid;
          ar_addr_q.push_back(m_bus.araddr);
          ar_len_q.push_back(32'(m_bus.arlen));
          ar_burst_q.push_back(32'(m_bus.arburst));
          ar_id_q.push_back(32'(m_bus.arid));
        end
        r_pend = m_bus.rvalid && m_bus.rready;
      end
    end
  end

  // Downstream write subordinate: always ready for AW/W, B one cycle after W.
  initial begin : wr_model
    logic w_pend;
    logic b_pend;
    w_pend = 1'b0; b_pend = 1'b0;
    m_bus.awready = 1'b1; m_bus.wready = 1'b1; m_bus.bvalid = 1'b0;
    m_bus.bresp = 2'd0; m_bus.bid = '0;
    forever begin
      @(negedge clk);
      if (b_pend) m_bus.bvalid = 1'b0;
      if (w_pend) begin
        m_bus.bvalid = 1'b1;
        m_bus.bresp  = bresp_tbl[bresp_idx[3:0]];
        bresp_idx++;
      end
      #1;
      if (!rst_n) begin
        m_bus.bvalid = 1'b0; w_pend = 1'b0; b_pend = 1'b0;
      end else begin
        if (m_bus.awvalid && m_bus.awready) begin
          m_bus.bid = m_bus.awid;
          aw_addr_q.push_back(m_bus.awaddr);
          aw_len_q.push_back(32'(m_bus.awlen));
          aw_burst_q.push_back(32'(m_bus.awburst));
          aw_id_q.push_back(32'(m_bus.awid));
        end
        w_pend = m_bus.wvalid && m_bus.wready;
        if (w_pend) begin
          w_data_q.push_back(m_bus.wdata);
          w_last_q.push_back(32'(m_bus.wlast));
        end
        b_pend = m_bus.bvalid && m_bus.bready;
      end
    end
  end

  task automatic clear_logs();
    ar_addr_q.delete(); ar_len_q.delete(); ar_burst_q.delete(); ar_id_q.delete();
    aw_addr_q.delete(); aw_len_q.delete(); aw_burst_q.delete(); aw_id_q.delete();
    w_data_q.delete(); w_last_q.delete();
    r_data_q.delete(); r_resp_q.delete(); r_last_q.delete(); r_id_q.delete();
    for (int i = 0; i < 16; i++) begin rresp_tbl[i] = 2'd0; bresp_tbl[i] = 2'd0; end
    rresp_idx = 0;
    bresp_idx = 0;
  endtask

  task automatic issue_ar(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    int n;
    @(negedge clk);
    s_bus.arvalid = 1'b1; s_bus.arid = id; s_bus.araddr = addr;
    s_bus.arlen = len; s_bus.arsize = size; s_bus.arburst = burst;
    #1;
    n = 0;
    while (!s_bus.arready && n < 50) begin @(negedge clk); #1; n++; end
    chk("ar_handshake", 64'(s_bus.arready), 64'd1);
    @(negedge clk);
    s_bus.arvalid = 1'b0;
  endtask

  task automatic collect_r(input int n);
    int got;
    int cyc;
    got = 0; cyc = 0;
    while (cyc < 200) begin
      @(negedge clk);
      if (got == n) break;
      s_bus.rready = 1'b1;
      #1;
      if (s_bus.rvalid) begin
        r_data_q.push_back(s_bus.rdata);
        r_resp_q.push_back(32'(s_bus.rresp));
        r_last_q.push_back(32'(s_bus.rlast));
        r_id_q.push_back(32'(s_bus.rid));
        got++;
      end
      cyc++;
    end
    s_bus.rready = 1'b0;
    chk("r_beats", 64'(got), 64'(n));
  endtask

  task automatic issue_aw(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    int n;
    @(negedge clk);
    s_bus.awvalid = 1'b1; s_bus.awid = id; s_bus.awaddr = addr;
    s_bus.awlen = len; s_bus.awsize = size; s_bus.awburst = burst;
    #1;
    n = 0;
    while (!s_bus.awready && n < 50) begin @(negedge clk); #1; n++; end
    chk("aw_handshake", 64'(s_bus.awready), 64'd1);
    @(negedge clk);
    s_bus.awvalid = 1'b0;
  endtask

  task automatic send_w(input int nbeats, input int early_idx);
    int n;
    int sent;
    sent = 0;
    for (int i = 0; i < nbeats; i++) begin
      @(negedge clk);
      s_bus.wvalid = 1'b1;
      s_bus.wdata  = w_src[i];
      s_bus.wstrb  = 4'hF;
      s_bus.wlast  = (i == nbeats - 1) || (i == early_idx);
      #1;
      n = 0;
      while (!s_bus.wready && n < 50) begin @(negedge clk); #1; n++; end
      if (s_bus.wready) sent++;
    end
    @(negedge clk);
    s_bus.wvalid = 1'b0; s_bus.wlast = 1'b0;
    chk("w_accepted", 64'(sent), 64'(nbeats));
  endtask

  task automatic get_b(output logic [1:0] resp, output logic [7:0] id);
    int n;
    @(negedge clk);
    s_bus.bready = 1'b1;
    #1;
    n = 0;
    while (!s_bus.bvalid && n < 100) begin @(negedge clk); #1; n++; end
    chk("b_seen", 64'(s_bus.bvalid), 64'd1);
    resp = s_bus.bresp;
    id   = s_bus.bid;
    @(negedge clk);
    s_bus.bready = 1'b0;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] ea[4];
    logic [1:0]  bresp;
    logic [7:0]  bid;
    checks = 0; failures = 0;
    rst_n = 1'b0;
    s_bus.arvalid = 1'b0; s_bus.arid = '0; s_bus.araddr = '0; s_bus.arlen = '0;
    s_bus.arsize = '0; s_bus.arburst = '0; s_bus.rready = 1'b0;
    s_bus.awvalid = 1'b0; s_bus.awid = '0; s_bus.awaddr = '0; s_bus.awlen = '0;
    s_bus.awsize = '0; s_bus.awburst = '0; s_bus.wvalid = 1'b0; s_bus.wdata = '0;
    s_bus.wstrb = '0; s_bus.wlast = 1'b0; s_bus.bready = 1'b0;
    clear_logs();

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_arready", 64'(s_bus.arready), 64'd1);
    chk("rst_awready", 64'(s_bus.awready), 64'd1);
    chk("rst_m_arvalid", 64'(m_bus.arvalid), 64'd0);
    chk("rst_m_awvalid", 64'(m_bus.awvalid), 64'd0);
    chk("rst_s_rvalid", 64'(s_bus.rvalid), 64'd0);
    chk("rst_s_bvalid", 64'(s_bus.bvalid), 64'd0);
    chk("rst_s_wready", 64'(s_bus.wready), 64'd0);
    chk("rst_m_araddr", 64'(m_bus.araddr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: WRAP read 0x108 size 2 len 3 id 5
    clear_logs();
    issue_ar(8'd5, 32'h108, 8'd3, 3'd2, WRAP);
    #1;
    chk("t1_arvalid_lat", 64'(m_bus.arvalid), 64'd1);
    collect_r(4);
    ea = '{32'h108, 32'h10C, 32'h100, 32'h104};
    chk("t1_ar_cnt", 64'(ar_addr_q.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_ar_addr%0d", i), 64'(qat(ar_addr_q, i)), 64'(ea[i]));
      chk($sformatf("t1_ar_len%0d", i), 64'(qat(ar_len_q, i)), 64'd0);
      chk($sformatf("t1_ar_burst%0d", i), 64'(qat(ar_burst_q, i)), 64'd1);
      chk($sformatf("t1_ar_id%0d", i), 64'(qat(ar_id_q, i)), 64'd5);
      chk($sformatf("t1_rdata%0d", i), 64'(qat(r_data_q, i)), 64'(32'hD000_0000 ^ ea[i]));
      chk($sformatf("t1_rlast%0d", i), 64'(qat(r_last_q, i)), 64'(i == 3));
      chk($sformatf("t1_rid%0d", i), 64'(qat(r_id_q, i)), 64'd5);
    end

    // 2: FIXED write 0x40 len 2
    clear_logs();
    w_src[0] = 32'hAAAA_0001; w_src[1] = 32'hBBBB_0002; w_src[2] = 32'hCCCC_0003;
    issue_aw(8'd7, 32'h40, 8'd2, 3'd2, FIXED);
    send_w(3, -1);
    get_b(bresp, bid);
    chk("t2_bresp", 64'(bresp), 64'd0);
    chk("t2_bid", 64'(bid), 64'd7);
    chk("t2_aw_cnt", 64'(aw_addr_q.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t2_aw_addr%0d", i), 64'(qat(aw_addr_q, i)), 64'h40);
      chk($sformatf("t2_aw_len%0d", i), 64'(qat(aw_len_q, i)), 64'd0);
      chk($sformatf("t2_aw_burst%0d", i), 64'(qat(aw_burst_q, i)), 64'd1);
      chk($sformatf("t2_aw_id%0d", i), 64'(qat(aw_id_q, i)), 64'd7);
      chk($sformatf("t2_wdata%0d", i), 64'(qat(w_data_q, i)), 64'(w_src[i]));
      chk($sformatf("t2_wlast%0d", i), 64'(qat(w_last_q, i)), 64'd1);
    end
    repeat (3) @(negedge clk);
    #1;
    chk("t2_single_b", 64'(s_bus.bvalid), 64'd0);

    // 3: INCR read 0x200 len 3, SLVERR on second downstream beat
    clear_logs();
    rresp_tbl[1] = 2'd2;
    issue_ar(8'd3, 32'h200, 8'd3, 3'd2, INCR);
    collect_r(4);
    ea = '{32'h200, 32'h204, 32'h208, 32'h20C};
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_ar_addr%0d", i), 64'(qat(ar_addr_q, i)), 64'(ea[i]));
      chk($sformatf("t3_rresp%0d", i), 64'(qat(r_resp_q, i)), (i == 1) ? 64'd2 : 64'd0);
      chk($sformatf("t3_rdata%0d", i), 64'(qat(r_data_q, i)), 64'(32'hD000_0000 ^ ea[i]));
    end

    // 4a: INCR write len 3, downstream SLVERR on beat 3
    clear_logs();
    bresp_tbl[2] = 2'd2;
    for (int i = 0; i < 4; i++) w_src[i] = 32'h1000_0000 + 32'(i);
    issue_aw(8'd9, 32'h300, 8'd3, 3'd2, INCR);
    send_w(4, -1);
    get_b(bresp, bid);
    chk("t4a_bresp", 64'(bresp), 64'd2);
    chk("t4a_bid", 64'(bid), 64'd9);
    chk("t4a_down_b_cnt", 64'(bresp_idx), 64'd4);
    ea = '{32'h300, 32'h304, 32'h308, 32'h30C};
    for (int i = 0; i < 4; i++)
      chk($sformatf("t4a_aw_addr%0d", i), 64'(qat(aw_addr_q, i)), 64'(ea[i]));

    // 4b: INCR write len 3 with wlast asserted early on the first beat
    clear_logs();
    issue_aw(8'd10, 32'h380, 8'd3, 3'd2, INCR);
    send_w(4, 0);
    get_b(bresp, bid);
    chk("t4b_bresp", 64'(bresp), 64'd2);
    chk("t4b_bid", 64'(bid), 64'd10);

    // 5a: invalid WRAP read (len 2)
    clear_logs();
    issue_ar(8'd1, 32'h100, 8'd2, 3'd2, WRAP);
    collect_r(3);
    chk("t5a_no_ar", 64'(ar_addr_q.size()), 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t5a_rresp%0d", i), 64'(qat(r_resp_q, i)), 64'd2);
      chk($sformatf("t5a_rdata%0d", i), 64'(qat(r_data_q, i)), 64'd0);
      chk($sformatf("t5a_rlast%0d", i), 64'(qat(r_last_q, i)), 64'(i == 2));
      chk($sformatf("t5a_rid%0d", i), 64'(qat(r_id_q, i)), 64'd1);
    end

    // 5b: invalid WRAP write (len 2)
    clear_logs();
    issue_aw(8'd2, 32'h100, 8'd2, 3'd2, WRAP);
    send_w(3, -1);
    get_b(bresp, bid);
    chk("t5b_bresp", 64'(bresp), 64'd2);
    chk("t5b_bid", 64'(bid), 64'd2);
    chk("t5b_no_aw", 64'(aw_addr_q.size()), 64'd0);
    chk("t5b_no_w", 64'(w_data_q.size()), 64'd0);

    // 6: reset mid-burst, then a clean single-beat read
    clear_logs();
    issue_ar(8'd4, 32'h400, 8'd3, 3'd2, INCR);
    collect_r(1);
    #1;
    chk("t6_mid_burst", 64'(m_bus.arvalid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_m_arvalid", 64'(m_bus.arvalid), 64'd0);
    chk("t6_rst_s_rvalid", 64'(s_bus.rvalid), 64'd0);
    chk("t6_rst_m_rready", 64'(m_bus.rready), 64'd0);
    chk("t6_rst_m_awvalid", 64'(m_bus.awvalid), 64'd0);
    chk("t6_rst_s_bvalid", 64'(s_bus.bvalid), 64'd0);
    chk("t6_rst_arready", 64'(s_bus.arready), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    issue_ar(8'd6, 32'h10, 8'd0, 3'd2, INCR);
    collect_r(1);
    chk("t6_ar_addr", 64'(qat(ar_addr_q, 0)), 64'h10);
    chk("t6_rdata", 64'(qat(r_data_q, 0)), 64'hD000_0010);
    chk("t6_rresp", 64'(qat(r_resp_q, 0)), 64'd0);
    chk("t6_rlast", 64'(qat(r_last_q, 0)), 64'd1);
    chk("t6_rid", 64'(qat(r_id_q, 0)), 64'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
